// File: rtl/hog_pkg.sv
// Shared types and sizing helpers for the HOG feature serializer.
// Imported by the block FIFO and the serializer top.
package hog_pkg;

  localparam int DROP_W = 16;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int fea_w(input int fi, input int ff);
    return fi + ff;
  endfunction

  function automatic int beats(input int nbin, input int ncell,
                               input int lanes);
    return (nbin * ncell) / lanes;
  endfunction

endpackage

// File: rtl/hog_blk_fifo.sv
// Whole-block FIFO with combinational head output.
// Writes into a full FIFO and reads from an empty one are ignored.
module hog_blk_fifo
  import hog_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DW-1:0]             din,
  output logic [DW-1:0]             head,
  output logic [clog2(DEPTH):0]     count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign head  = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  // Block storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/hog_fea_serializer.sv
// Buffers normalised HOG blocks and streams them as LANES
// features per beat with block/window boundary flags.
module hog_fea_serializer
  import hog_pkg::*;
#(
  parameter int FEA_I       = 4,
  parameter int FEA_F       = 28,
  parameter int NBIN        = 9,
  parameter int NCELL       = 4,
  parameter int LANES       = 1,
  parameter int DEPTH       = 4,
  parameter int BLK_PER_WIN = 105,
  parameter int BLK_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  input  logic [NCELL*NBIN*(FEA_I+FEA_F)-1:0]  i_fea,
  output logic                                 i_ready,
  input  logic                                 clr_ovf,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [LANES*(FEA_I+FEA_F)-1:0]       o_data,
  output logic                                 o_sop,
  output logic                                 o_eop,
  output logic                                 o_eow,
  output logic [BLK_W-1:0]                     o_blk_idx,
  output logic                                 ovf,
  output logic [DROP_W-1:0]                    drop_cnt
);

  localparam int FW = fea_w(FEA_I, FEA_F);
  localparam int NB = beats(NBIN, NCELL, LANES);
  localparam int BW = (clog2(NB) > 0) ? clog2(NB) : 1;
  localparam int DW = NCELL * NBIN * FW;
  localparam int LW = LANES * FW;
  localparam int AW = clog2(DEPTH);

  state_t              state;
  state_t              state_nx;
  logic [BW-1:0]       beat;
  logic [DW-1:0]       head;
  logic [NB-1:0][LW-1:0] beat_v;
  logic [AW:0]         count;
  logic [AW:0]         count_nx;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                drop;
  logic                xfer;
  logic                last;

  hog_blk_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (i_fea),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign push     = i_valid && !full;
  assign drop     = i_valid && full;
  assign xfer     = o_valid && o_ready;
  assign last     = (beat == BW'(NB-1));
  assign pop      = xfer && last;
  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
  assign i_ready  = !full;

  assign beat_v    = head;
  assign o_valid   = (state == STREAM);
  assign o_data    = beat_v[beat];
  assign o_sop     = o_valid && (beat == '0);
  assign o_eop     = o_valid && last;
  assign o_eow     = o_eop && (o_blk_idx == BLK_W'(BLK_PER_WIN-1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Stream while any block is buffered; a fresh push starts at once.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (push || !empty) state_nx = STREAM;
      STREAM: if (pop && count_nx == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Beat position within the head block.
  always_ff @(posedge clk) begin
    if (rst)       beat <= '0;
    else if (xfer) beat <= last ? '0 : beat + 1'b1;
  end

  // Block index within the detection window, advanced per sent block.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_blk_idx <= '0;
    end else if (pop) begin
      if (o_blk_idx == BLK_W'(BLK_PER_WIN-1)) o_blk_idx <= '0;
      else                                    o_blk_idx <= o_blk_idx + 1'b1;
    end
  end

  // Overflow tracking; a drop takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (clr_ovf)             drop_cnt <= DROP_W'(1);
      else if (&drop_cnt)      drop_cnt <= drop_cnt;
      else                     drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_hog_fea_serializer.sv
// Scoreboard bench for hog_fea_serializer: one LANES=1 instance
// with a 3-block window and one LANES=4 instance.
module tb_hog_fea_serializer;

  localparam int NF = 36;

  typedef struct {
    logic [127:0] d;
    logic         sop;
    logic         eop;
    logic         eow;
    logic [7:0]   idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  logic          a_iv, a_irdy, a_clr, a_ov, a_ordy;
  logic [1151:0] a_fea;
  logic [31:0]   a_dat;
  logic          a_sop, a_eop, a_eow, a_ovf;
  logic [7:0]    a_idx;
  logic [15:0]   a_drop;

  logic          b_iv, b_irdy, b_clr, b_ov, b_ordy;
  logic [1151:0] b_fea;
  logic [127:0]  b_dat;
  logic          b_sop, b_eop, b_eow, b_ovf;
  logic [7:0]    b_idx;
  logic [15:0]   b_drop;

  beat_t qa[$];
  beat_t qb[$];
  beat_t ea, eb;
  int    idx_a, idx_b;
  int    eow_cnt;
  int    n_chk, n_err;

  always #5 clk = ~clk;

  hog_fea_serializer #(
    .LANES(1), .DEPTH(4), .BLK_PER_WIN(3), .BLK_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .i_valid(a_iv), .i_fea(a_fea),
    .i_ready(a_irdy), .clr_ovf(a_clr), .o_valid(a_ov),
    .o_ready(a_ordy), .o_data(a_dat), .o_sop(a_sop),
    .o_eop(a_eop), .o_eow(a_eow), .o_blk_idx(a_idx),
    .ovf(a_ovf), .drop_cnt(a_drop)
  );

  hog_fea_serializer #(
    .LANES(4), .DEPTH(4), .BLK_PER_WIN(105), .BLK_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .i_valid(b_iv), .i_fea(b_fea),
    .i_ready(b_irdy), .clr_ovf(b_clr), .o_valid(b_ov),
    .o_ready(b_ordy), .o_data(b_dat), .o_sop(b_sop),
    .o_eop(b_eop), .o_eow(b_eow), .o_blk_idx(b_idx),
    .ovf(b_ovf), .drop_cnt(b_drop)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fval(input int blk, input int f);
    return 32'(blk * 65536 + f + 1);
  endfunction

  function automatic logic [1151:0] mkblk(input int blk);
    logic [1151:0] v;
    for (int f = 0; f < NF; f++) v[f*32 +: 32] = fval(blk, f);
    return v;
  endfunction

  task automatic push_exp(input int which, input int blk);
    int    lanes, nb, bpw, idx;
    beat_t e;
    lanes = which ? 4 : 1;
    bpw   = which ? 105 : 3;
    nb    = NF / lanes;
    idx   = which ? idx_b : idx_a;
    for (int k = 0; k < nb; k++) begin
      e.d = '0;
      for (int l = 0; l < lanes; l++)
        e.d[l*32 +: 32] = fval(blk, k*lanes + l);
      e.sop = (k == 0);
      e.eop = (k == nb-1);
      e.idx = 8'(idx);
      e.eow = e.eop && (idx == bpw-1);
      if (which != 0) qb.push_back(e);
      else            qa.push_back(e);
    end
    idx = (idx == bpw-1) ? 0 : idx + 1;
    if (which != 0) idx_b = idx;
    else            idx_a = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int blk, input bit accept);
    a_iv  = 1'b1;
    a_fea = mkblk(blk);
    if (accept) push_exp(0, blk);
    tick();
    a_iv = 1'b0;
  endtask

  task automatic send_b(input int blk);
    b_iv  = 1'b1;
    b_fea = mkblk(blk);
    push_exp(1, blk);
    tick();
    b_iv = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 400 && qa.size() != 0; i++) tick();
    chk(tag, 128'(qa.size()), 128'(0));
  endtask

  // Scoreboard for instance A; also checks held values during stalls.
  always @(negedge clk) begin
    if (!rst && a_ov) begin
      chk("a_have", 128'(qa.size() != 0), 128'(1));
      if (qa.size() != 0) begin
        ea = qa[0];
        chk("a_data", 128'(a_dat), ea.d);
        chk("a_sop", 128'(a_sop), 128'(ea.sop));
        chk("a_eop", 128'(a_eop), 128'(ea.eop));
        chk("a_eow", 128'(a_eow), 128'(ea.eow));
        chk("a_idx", 128'(a_idx), 128'(ea.idx));
        if (a_ordy) begin
          void'(qa.pop_front());
          if (a_eow) eow_cnt++;
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (!rst && b_ov) begin
      chk("b_have", 128'(qb.size() != 0), 128'(1));
      if (qb.size() != 0) begin
        eb = qb[0];
        chk("b_data", b_dat, eb.d);
        chk("b_sop", 128'(b_sop), 128'(eb.sop));
        chk("b_eop", 128'(b_eop), 128'(eb.eop));
        chk("b_eow", 128'(b_eow), 128'(eb.eow));
        chk("b_idx", 128'(b_idx), 128'(eb.idx));
        if (b_ordy) void'(qb.pop_front());
      end
    end
  end

  initial begin
    n_chk = 0; n_err = 0; eow_cnt = 0;
    idx_a = 0; idx_b = 0;
    rst = 1'b1;
    a_iv = 0; a_fea = '0; a_clr = 0; a_ordy = 1;
    b_iv = 0; b_fea = '0; b_clr = 0; b_ordy = 1;
    tick();
    tick();
    chk("rst_a_ov", 128'(a_ov), 128'(0));
    chk("rst_a_sop", 128'(a_sop), 128'(0));
    chk("rst_a_eop", 128'(a_eop), 128'(0));
    chk("rst_a_eow", 128'(a_eow), 128'(0));
    chk("rst_a_idx", 128'(a_idx), 128'(0));
    chk("rst_a_ovf", 128'(a_ovf), 128'(0));
    chk("rst_a_drop", 128'(a_drop), 128'(0));
    chk("rst_a_irdy", 128'(a_irdy), 128'(1));
    chk("rst_b_ov", 128'(b_ov), 128'(0));
    chk("rst_b_irdy", 128'(b_irdy), 128'(1));
    rst = 1'b0;
    tick();

    // single block, LANES=1, first beat one cycle after the write
    send_a(0, 1'b1);
    chk("lat_valid", 128'(a_ov), 128'(1));
    chk("lat_sop", 128'(a_sop), 128'(1));
    chk("lat_data", 128'(a_dat), 128'(1));
    chk("lat_idx", 128'(a_idx), 128'(0));
    drain_a("t1_drain");
    tick();
    chk("t1_idle", 128'(a_ov), 128'(0));
    chk("t1_idx", 128'(a_idx), 128'(1));

    // LANES=4, two back-to-back blocks with no bubble
    send_b(0);
    chk("b_lane0", b_dat, {fval(0,3), fval(0,2), fval(0,1), fval(0,0)});
    send_b(1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("b_b2b", 128'(b_ov), 128'(1));
    end
    @(negedge clk);
    chk("b_idle", 128'(b_ov), 128'(0));
    chk("b_empty", 128'(qb.size()), 128'(0));
    chk("b_idx", 128'(b_idx), 128'(2));
    tick();

    // o_ready toggling 1,0,0,1 throughout a block
    send_a(1, 1'b1);
    for (int i = 0; i < 300 && qa.size() != 0; i++) begin
      a_ordy = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    a_ordy = 1'b1;
    chk("t3_drain", 128'(qa.size()), 128'(0));

    // overflow with the sink stalled
    a_ordy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_a(10 + i, i < 4);
      if (i == 2) chk("irdy_3", 128'(a_irdy), 128'(1));
      if (i == 3) chk("irdy_4", 128'(a_irdy), 128'(0));
    end
    chk("ovf_set", 128'(a_ovf), 128'(1));
    chk("drop_2", 128'(a_drop), 128'(2));
    a_clr = 1'b1;
    send_a(20, 1'b0);
    a_clr = 1'b0;
    chk("clr_drop_ovf", 128'(a_ovf), 128'(1));
    chk("clr_drop_cnt", 128'(a_drop), 128'(1));
    a_ordy = 1'b1;
    drain_a("t4_drain");
    chk("irdy_back", 128'(a_irdy), 128'(1));
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_cnt", 128'(a_drop), 128'(0));
    chk("clr_ovf", 128'(a_ovf), 128'(0));

    // reset mid-block with two blocks queued
    send_a(30, 1'b1);
    send_a(31, 1'b1);
    send_a(32, 1'b1);
    repeat (8) tick();
    chk("pre_rst_ov", 128'(a_ov), 128'(1));
    rst = 1'b1;
    qa.delete();
    idx_a = 0;
    tick();
    rst = 1'b0;
    chk("post_rst_ov", 128'(a_ov), 128'(0));
    chk("post_rst_idx", 128'(a_idx), 128'(0));
    chk("post_rst_irdy", 128'(a_irdy), 128'(1));
    tick();
    chk("post_rst_idle", 128'(a_ov), 128'(0));
    send_a(33, 1'b1);
    chk("rst_new_sop", 128'(a_sop), 128'(1));
    chk("rst_new_drop", 128'(a_drop), 128'(0));
    drain_a("t6_drain");

    // window boundaries with a 3-block window
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idx_a = 0;
    eow_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      send_a(40 + k, 1'b1);
      drain_a("t5_drain");
    end
    chk("eow_cnt", 128'(eow_cnt), 128'(2));
    chk("t5_idx", 128'(a_idx), 128'(1));

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
